axi4_lite_arbiter_rd: RTL and testbench

- Two-master to one-slave AXI4-lite read arbiter. It merges the read channels of two upstream masters into a single read stream for the downstream address-split read fanout.
- AR is arbitrated round-robin and registered.
- R responses are routed back in order using a small order FIFO of grant indices. The downstream slave returns reads in AR order.

---
 rtl/axi4_lite_pkg.sv | 17 +
 rtl/axi4_lite_order_fifo.sv | 70 +++++++
 rtl/axi4_lite_arbiter_rd.sv | 113 +++++++++++
 tb/tb_axi4_lite_arbiter_rd.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi4_lite_pkg
// Description : Shared AXI4-lite response codes and grant index type.
// Revision    : 1.0 - initial release
// ============================================================================
package axi4_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef logic grant_t;

endpackage
`default_nettype wire

// File: rtl/axi4_lite_order_fifo.sv
`default_nettype none
// ============================================================================
// Module      : axi4_lite_order_fifo
// Description : Synchronous FIFO of grant indices, depth D, for in-order
//               response routing.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_lite_order_fifo
   import axi4_lite_pkg::*;
#(
   parameter int D  = 4,
   localparam int CW = $clog2(D + 1)
) (
   input  logic          aclk,
   input  logic          aresetn,
   input  logic          push,
   input  grant_t        push_idx,
   input  logic          pop,
   output grant_t        head,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   localparam int PW = (D > 1) ? $clog2(D) : 1;
   localparam logic [PW-1:0] c_last  = PW'(D - 1);
   localparam logic [CW-1:0] c_depth = CW'(D);

   grant_t        r_mem [D];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_push;
   logic          w_pop;

   assign empty  = (r_count == '0);
   assign full   = (r_count == c_depth);
   assign count  = r_count;
   assign head   = r_mem[r_rd_ptr];
   assign w_push = push & ~full;
   assign w_pop  = pop & ~empty;

   always_ff @(posedge aclk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= push_idx;
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= (r_rd_ptr == c_last) ? '0 : r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/axi4_lite_arbiter_rd.sv
`default_nettype none
// ============================================================================
// Module      : axi4_lite_arbiter_rd
// Description : Two-master to one-slave AXI4-lite read arbiter, round-robin
//               registered AR, in-order R routing via an order FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_lite_arbiter_rd
   import axi4_lite_pkg::*;
#(
   parameter int A = 32,
   parameter int N = 4,
   parameter int D = 4
) (
   input  logic           aclk,
   input  logic           aresetn,
   input  logic [A-1:0]   s0_araddr,
   input  logic           s0_arvalid,
   output logic           s0_arready,
   output logic [8*N-1:0] s0_rdata,
   output logic [1:0]     s0_rresp,
   output logic           s0_rvalid,
   input  logic           s0_rready,
   input  logic [A-1:0]   s1_araddr,
   input  logic           s1_arvalid,
   output logic           s1_arready,
   output logic [8*N-1:0] s1_rdata,
   output logic [1:0]     s1_rresp,
   output logic           s1_rvalid,
   input  logic           s1_rready,
   output logic [A-1:0]   m_araddr,
   output logic           m_arvalid,
   input  logic           m_arready,
   input  logic [8*N-1:0] m_rdata,
   input  logic [1:0]     m_rresp,
   input  logic           m_rvalid,
   output logic           m_rready
);

   localparam int CW = $clog2(D + 1);
   localparam logic [CW-1:0] c_depth = CW'(D);

   logic          r_m_arvalid;
   logic [A-1:0]  r_m_araddr;
   grant_t        r_last_grant;
   grant_t        w_grant;
   grant_t        w_head;
   logic          w_can_load;
   logic          w_acc0;
   logic          w_acc1;
   logic          w_accept;
   logic          w_pop;
   logic          w_full;
   logic          w_empty;
   logic [CW-1:0] w_count;

   // Simultaneous requests go to whichever master did not win last.
   assign w_grant    = (s0_arvalid & s1_arvalid) ? ~r_last_grant : s1_arvalid;
   assign w_can_load = (~r_m_arvalid | m_arready) & ~w_full;
   assign w_acc0     = w_can_load & s0_arvalid & (w_grant == 1'b0);
   assign w_acc1     = w_can_load & s1_arvalid & (w_grant == 1'b1);
   assign w_accept   = w_acc0 | w_acc1;

   assign s0_arready = w_acc0;
   assign s1_arready = w_acc1;
   assign m_arvalid  = r_m_arvalid;
   assign m_araddr   = r_m_araddr;

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_m_arvalid  <= 1'b0;
         r_m_araddr   <= '0;
         r_last_grant <= 1'b1;
      end else if (w_accept) begin
         r_m_arvalid  <= 1'b1;
         r_m_araddr   <= w_acc1 ? s1_araddr : s0_araddr;
         r_last_grant <= w_acc1;
      end else if (m_arready) begin
         r_m_arvalid  <= 1'b0;
      end
   end

   axi4_lite_order_fifo #(
      .D (D)
   ) u_order_fifo (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .push     (w_accept),
      .push_idx (w_acc1),
      .pop      (w_pop),
      .head     (w_head),
      .count    (w_count),
      .full     (w_full),
      .empty    (w_empty)
   );

   // Response routing follows the oldest outstanding grant; data is broadcast.
   assign s0_rvalid = m_rvalid & ~w_empty & (w_head == 1'b0);
   assign s1_rvalid = m_rvalid & ~w_empty & (w_head == 1'b1);
   assign m_rready  = ~w_empty & (w_head ? s1_rready : s0_rready);
   assign w_pop     = m_rvalid & m_rready;
   assign s0_rdata  = m_rdata;
   assign s1_rdata  = m_rdata;
   assign s0_rresp  = m_rresp;
   assign s1_rresp  = m_rresp;

   a_no_orphan_r: assert property (@(posedge aclk) disable iff (!aresetn)
      !(m_rvalid && w_empty));
   a_count_bound: assert property (@(posedge aclk) disable iff (!aresetn)
      w_count <= c_depth);

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_arbiter_rd.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi4_lite_arbiter_rd
// Description : Directed and randomized bench for axi4_lite_arbiter_rd with a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_lite_arbiter_rd;

   localparam int A = 32;
   localparam int N = 4;
   localparam int D = 4;

   logic           aclk = 1'b0;
   logic           aresetn;
   logic [A-1:0]   s0_araddr, s1_araddr, m_araddr;
   logic           s0_arvalid, s1_arvalid, s0_arready, s1_arready;
   logic [8*N-1:0] s0_rdata, s1_rdata, m_rdata;
   logic [1:0]     s0_rresp, s1_rresp, m_rresp;
   logic           s0_rvalid, s1_rvalid, s0_rready, s1_rready;
   logic           m_arvalid, m_arready, m_rvalid, m_rready;

   int total = 0;
   int bad   = 0;

   // Reference model state: order of outstanding grants, pending downstream AR.
   bit           mq[$];
   bit           mdl_arv;
   logic [A-1:0] mdl_addr;
   bit           mdl_last;
   bit           mdl_ok = 1'b0;
   int           sq_n;
   bit           hs_r = 1'b0;

   axi4_lite_arbiter_rd #(.A(A), .N(N), .D(D)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s0_araddr(s0_araddr), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
      .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
      .s1_araddr(s1_araddr), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
      .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
      .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic void calc(output bit ar0, output bit ar1, output bit r0v,
                                output bit r1v, output bit mrr);
      bit empty = (mq.size() == 0);
      bit h     = empty ? 1'b0 : mq[0];
      bit can   = (!mdl_arv || m_arready) && (mq.size() < D);
      ar0 = can && s0_arvalid && (!s1_arvalid || mdl_last);
      ar1 = can && s1_arvalid && (!s0_arvalid || !mdl_last);
      r0v = m_rvalid && !empty && !h;
      r1v = m_rvalid && !empty && h;
      mrr = !empty && (h ? s1_rready : s0_rready);
   endfunction

   always @(posedge aclk) begin
      bit a0, a1, r0, r1, mr;
      calc(a0, a1, r0, r1, mr);
      hs_r = m_rvalid && mr;
      if (!aresetn) begin
         mq.delete();
         mdl_arv  = 1'b0;
         mdl_addr = '0;
         mdl_last = 1'b1;
         sq_n     = 0;
         mdl_ok   = 1'b1;
      end else if (mdl_ok) begin
         if (mdl_arv && m_arready) sq_n++;
         if (hs_r) begin
            void'(mq.pop_front());
            sq_n--;
         end
         if (a0 || a1) begin
            mq.push_back(a1);
            mdl_arv  = 1'b1;
            mdl_addr = a1 ? s1_araddr : s0_araddr;
            mdl_last = a1;
         end else if (mdl_arv && m_arready) begin
            mdl_arv = 1'b0;
         end
      end
   end

   always @(negedge aclk) begin
      bit a0, a1, r0, r1, mr;
      if (mdl_ok && aresetn) begin
         calc(a0, a1, r0, r1, mr);
         chk("m_arvalid", m_arvalid, mdl_arv);
         chk("m_araddr", m_araddr, mdl_addr);
         chk("s0_arready", s0_arready, a0);
         chk("s1_arready", s1_arready, a1);
         chk("s0_rvalid", s0_rvalid, r0);
         chk("s1_rvalid", s1_rvalid, r1);
         chk("m_rready", m_rready, mr);
         chk("s0_rdata", s0_rdata, m_rdata);
         chk("s1_rdata", s1_rdata, m_rdata);
         chk("s0_rresp", s0_rresp, m_rresp);
         chk("s1_rresp", s1_rresp, m_rresp);
      end
   end

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic reset_dut();
      aresetn    = 1'b0;
      m_rvalid   = 1'b0;
      s0_arvalid = 1'b0;
      s1_arvalid = 1'b0;
      tick();
      tick();
      aresetn = 1'b1;
   endtask

   task automatic drain();
      int guard = 0;
      m_arready = 1'b1;
      s0_rready = 1'b1;
      s1_rready = 1'b1;
      while (mq.size() > 0 && guard < 60) begin
         m_rvalid = (sq_n > 0);
         m_rdata  = $urandom;
         m_rresp  = 2'($urandom_range(0, 3));
         tick();
         guard++;
      end
      m_rvalid = 1'b0;
      if (guard >= 60) chk("drain_timeout", 1, 0);
   endtask

   initial begin
      int n_acc;
      aresetn = 1'b0;
      s0_araddr = '0; s1_araddr = '0; s0_arvalid = 0; s1_arvalid = 0;
      s0_rready = 1; s1_rready = 1; m_arready = 0;
      m_rdata = '0; m_rresp = '0; m_rvalid = 0;
      reset_dut();

      // Single read from s0
      s0_araddr = 32'h100; s0_arvalid = 1; m_arready = 1;
      @(negedge aclk); chk("t1_s0_arready", s0_arready, 1);
      tick(); s0_arvalid = 0;
      @(negedge aclk); chk("t1_m_arvalid", m_arvalid, 1); chk("t1_m_araddr", m_araddr, 32'h100);
      tick(); m_rvalid = 1; m_rdata = 32'hDEADBEEF; m_rresp = 2'b00;
      @(negedge aclk);
      chk("t1_s0_rvalid", s0_rvalid, 1); chk("t1_s1_rvalid", s1_rvalid, 0);
      chk("t1_s0_rdata", s0_rdata, 32'hDEADBEEF); chk("t1_s0_rresp", s0_rresp, 0);
      tick(); m_rvalid = 0;

      // Round-robin alternation from reset
      reset_dut();
      s0_araddr = 32'h10; s1_araddr = 32'h20; s0_arvalid = 1; s1_arvalid = 1; m_arready = 1;
      for (int i = 0; i < 5; i++) begin
         @(negedge aclk);
         if (i < 4) begin
            chk("t2_s0_arready", s0_arready, (i % 2) == 0);
            chk("t2_s1_arready", s1_arready, (i % 2) == 1);
         end else begin
            chk("t2_full_stall", s0_arready | s1_arready, 0);
         end
         if (i > 0) chk("t2_m_araddr", m_araddr, ((i - 1) % 2) ? 32'h20 : 32'h10);
         tick();
      end
      s0_arvalid = 0; s1_arvalid = 0;
      drain();

      // Outstanding limit
      reset_dut();
      s0_araddr = 32'h200; s0_arvalid = 1; m_arready = 1; n_acc = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge aclk); n_acc += int'(s0_arready);
         tick();
      end
      chk("t3_accepted", n_acc, 4);
      @(negedge aclk); chk("t3_stall", s0_arready, 0);
      tick(); m_rvalid = 1; m_rdata = 32'h1;
      @(negedge aclk); chk("t3_same_cycle", s0_arready, 0); chk("t3_m_rready", m_rready, 1);
      tick(); m_rvalid = 0;
      @(negedge aclk); chk("t3_next_cycle", s0_arready, 1);
      tick(); s0_arvalid = 0;
      drain();

      // In-order routing with R backpressure
      reset_dut();
      s1_araddr = 32'h300; s1_arvalid = 1;
      @(negedge aclk); chk("t4_acc_s1a", s1_arready, 1);
      tick(); s1_arvalid = 0; s0_araddr = 32'h304; s0_arvalid = 1;
      @(negedge aclk); chk("t4_acc_s0", s0_arready, 1);
      tick(); s0_arvalid = 0; s1_arvalid = 1;
      @(negedge aclk); chk("t4_acc_s1b", s1_arready, 1);
      tick(); s1_arvalid = 0;
      tick(); s1_rready = 0; m_rvalid = 1; m_rdata = 32'hA;
      @(negedge aclk);
      chk("t4_a_s1_rvalid", s1_rvalid, 1); chk("t4_a_s0_rvalid", s0_rvalid, 0);
      chk("t4_a_blocked", m_rready, 0);
      tick();
      @(negedge aclk); chk("t4_a_still_blocked", m_rready, 0);
      tick(); s1_rready = 1;
      @(negedge aclk); chk("t4_a_released", m_rready, 1); chk("t4_a_data", s1_rdata, 32'hA);
      tick(); m_rdata = 32'hB;
      @(negedge aclk); chk("t4_b_s0_rvalid", s0_rvalid, 1); chk("t4_b_s1_rvalid", s1_rvalid, 0);
      chk("t4_b_data", s0_rdata, 32'hB);
      tick(); m_rdata = 32'hC;
      @(negedge aclk); chk("t4_c_s1_rvalid", s1_rvalid, 1); chk("t4_c_data", s1_rdata, 32'hC);
      tick(); m_rvalid = 0;

      // AR backpressure
      reset_dut();
      m_arready = 0; s0_araddr = 32'h44; s0_arvalid = 1;
      tick(); s0_araddr = 32'h55; s1_araddr = 32'h66; s1_arvalid = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge aclk);
         chk("t5_hold_addr", m_araddr, 32'h44); chk("t5_hold_valid", m_arvalid, 1);
         chk("t5_no_ar", s0_arready | s1_arready, 0);
         tick();
      end
      m_arready = 1;
      @(negedge aclk); chk("t5_resume_s1", s1_arready, 1); chk("t5_resume_s0", s0_arready, 0);
      tick(); s0_arvalid = 0; s1_arvalid = 0;
      @(negedge aclk); chk("t5_new_addr", m_araddr, 32'h66);

      // Reset with reads outstanding
      aresetn = 0;
      tick(); aresetn = 1;
      @(negedge aclk);
      chk("t6_m_arvalid", m_arvalid, 0); chk("t6_empty", m_rready, 0);
      chk("t6_rvalid", s0_rvalid | s1_rvalid, 0);
      tick(); s0_araddr = 32'h70; s1_araddr = 32'h74; s0_arvalid = 1; s1_arvalid = 1;
      @(negedge aclk); chk("t6_s0_first", s0_arready, 1); chk("t6_s1_wait", s1_arready, 0);
      tick(); s0_arvalid = 0; s1_arvalid = 0;
      drain();

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         s0_arvalid = 1'($urandom_range(0, 1));
         s1_arvalid = 1'($urandom_range(0, 1));
         s0_araddr  = $urandom;
         s1_araddr  = $urandom;
         m_arready  = ($urandom_range(0, 3) != 0);
         s0_rready  = ($urandom_range(0, 3) != 0);
         s1_rready  = ($urandom_range(0, 3) != 0);
         if (!(m_rvalid && !hs_r)) begin
            m_rvalid = (sq_n > 0) && ($urandom_range(0, 2) != 0);
            m_rdata  = $urandom;
            m_rresp  = 2'($urandom_range(0, 3));
         end
         tick();
      end
      s0_arvalid = 0; s1_arvalid = 0;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
